// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Hazard detection and forwarding control for a 5-stage MIPS pipeline. It sits
// beside the decode stage and takes the control word of each decoded
// instruction. Those fields are carried through an internal shadow pipeline
// (EX, MEM, WB) that mirrors the datapath. From that pipeline the block
// produces:
//   - the stall controls,
//   - the D/E flushes,
//   - the forwarding selects for the D comparator and the EX ALU,
//   - a sticky watchdog error.
//
// Optional feature: define HAZARD_PERF_EN to add two free-running
// performance counters (stall_cycles, flush_cycles).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   rs_d, rt_d        source register fields of the instruction in D
//   uses_rs_d/rt_d    D instruction actually reads rs / rt
//   write_reg_d       destination register selected in D
//   reg_write_d       control word: writes the register file
//   mem_to_reg_d      control word: load
//   branch_d          control word: conditional branch (compares in D)
//   jump_d            control word: jump
//   jump_reg_d        control word: jump register (reads rs in D)
//   branch_taken_d    branch comparator result in D
//   stall_f, stall_d  hold PC / hold F/D register
//   flush_d           clear F/D register
//   flush_e           insert a bubble into D/E register
//   forward_a_d/b_d   D comparator operand from MEM ALU result
//   forward_a_e/b_e   EX operand select: 00 regfile, 01 WB, 10 MEM ALU
//   hazard_err        sticky watchdog error (stall run too long)
//   stall_cycles      (HAZARD_PERF_EN) count of stalled cycles
//   flush_cycles      (HAZARD_PERF_EN) count of flush_d cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_STALL  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  uses_rs_d,
    input  logic                  uses_rt_d,
    input  logic [REG_ADDR_W-1:0] write_reg_d,
    input  logic                  reg_write_d,
    input  logic                  mem_to_reg_d,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic                  jump_reg_d,
    input  logic                  branch_taken_d,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  forward_a_d,
    output logic                  forward_b_d,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles,
`endif
    output logic                  hazard_err
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG    = {REG_ADDR_W{1'b0}};
    localparam logic [2:0]            STALL_LIMIT = 3'(MAX_STALL);
    localparam logic [2:0]            RUN_MAX     = 3'd7;

    // Shadow pipeline: EX stage
    logic [REG_ADDR_W-1:0] ex_rs_r;
    logic [REG_ADDR_W-1:0] ex_rt_r;
    logic                  ex_uses_rs_r;
    logic                  ex_uses_rt_r;
    logic [REG_ADDR_W-1:0] ex_dst_r;
    logic                  ex_reg_write_r;
    logic                  ex_mem_to_reg_r;
    // Shadow pipeline: MEM stage
    logic [REG_ADDR_W-1:0] mem_dst_r;
    logic                  mem_reg_write_r;
    logic                  mem_mem_to_reg_r;
    // Shadow pipeline: WB stage
    logic [REG_ADDR_W-1:0] wb_dst_r;
    logic                  wb_reg_write_r;

    // Watchdog state
    logic [2:0]            stall_run_r;
    logic                  err_r;

    // Combinational hazard terms
    logic                  hit_ex_rs_s;
    logic                  hit_ex_rt_s;
    logic                  hit_mem_rs_s;
    logic                  hit_mem_rt_s;
    logic                  lw_stall_s;
    logic                  br_rs_s;
    logic                  br_rt_s;
    logic                  br_stall_s;
    logic                  stall_s;
    logic                  flush_s;

    // A stage "hits" a register when it will write it and it is not $0.
    function automatic logic reg_hit(
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] r
    );
        return wr & (dst == r) & (r != ZERO_REG);
    endfunction

    // EX operand select: MEM result wins over WB because it is younger.
    function automatic logic [1:0] ex_fwd_sel(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] r,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_dst
    );
        logic [1:0] sel;
        if (uses & reg_hit(mem_wr, mem_dst, r)) begin
            sel = 2'b10;
        end else if (uses & reg_hit(wb_wr, wb_dst, r)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Stall and flush detection from the D fields against the shadow stages.
    always_comb begin
        hit_ex_rs_s  = reg_hit(ex_reg_write_r, ex_dst_r, rs_d);
        hit_ex_rt_s  = reg_hit(ex_reg_write_r, ex_dst_r, rt_d);
        hit_mem_rs_s = reg_hit(mem_reg_write_r, mem_dst_r, rs_d);
        hit_mem_rt_s = reg_hit(mem_reg_write_r, mem_dst_r, rt_d);

        // Load result is not ready for the EX stage of the next instruction.
        lw_stall_s = ex_mem_to_reg_r &
                     ((uses_rs_d & hit_ex_rs_s) | (uses_rt_d & hit_ex_rt_s));

        // D-stage compare needs the value by the end of D: anything still in
        // EX is too late, and a load in MEM only has its data at the end of MEM.
        br_rs_s    = hit_ex_rs_s | (mem_mem_to_reg_r & hit_mem_rs_s);
        br_rt_s    = hit_ex_rt_s | (mem_mem_to_reg_r & hit_mem_rt_s);
        br_stall_s = ((branch_d | jump_reg_d) & br_rs_s) | (branch_d & br_rt_s);

        stall_s = lw_stall_s | br_stall_s;
        // A stalled branch/jump is re-evaluated once the stall clears.
        flush_s = (jump_d | branch_taken_d) & ~stall_s;
    end

    // Output drive: stall/flush and forwarding selects.
    always_comb begin
        stall_f     = stall_s;
        stall_d     = stall_s;
        flush_e     = stall_s;
        flush_d     = flush_s;
        // D forwarding only from an ALU result in MEM; the regfile writes in
        // the first half-cycle so WB needs no path into D.
        forward_a_d = hit_mem_rs_s & ~mem_mem_to_reg_r;
        forward_b_d = hit_mem_rt_s & ~mem_mem_to_reg_r;
        forward_a_e = ex_fwd_sel(ex_uses_rs_r, ex_rs_r, mem_reg_write_r, mem_dst_r,
                                 wb_reg_write_r, wb_dst_r);
        forward_b_e = ex_fwd_sel(ex_uses_rt_r, ex_rt_r, mem_reg_write_r, mem_dst_r,
                                 wb_reg_write_r, wb_dst_r);
        hazard_err  = err_r;
    end

    // Shadow pipeline advance; a stall pushes a bubble into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs_r          <= ZERO_REG;
            ex_rt_r          <= ZERO_REG;
            ex_uses_rs_r     <= 1'b0;
            ex_uses_rt_r     <= 1'b0;
            ex_dst_r         <= ZERO_REG;
            ex_reg_write_r   <= 1'b0;
            ex_mem_to_reg_r  <= 1'b0;
            mem_dst_r        <= ZERO_REG;
            mem_reg_write_r  <= 1'b0;
            mem_mem_to_reg_r <= 1'b0;
            wb_dst_r         <= ZERO_REG;
            wb_reg_write_r   <= 1'b0;
        end else begin
            if (stall_s) begin
                ex_rs_r         <= ZERO_REG;
                ex_rt_r         <= ZERO_REG;
                ex_uses_rs_r    <= 1'b0;
                ex_uses_rt_r    <= 1'b0;
                ex_dst_r        <= ZERO_REG;
                ex_reg_write_r  <= 1'b0;
                ex_mem_to_reg_r <= 1'b0;
            end else begin
                ex_rs_r         <= rs_d;
                ex_rt_r         <= rt_d;
                ex_uses_rs_r    <= uses_rs_d;
                ex_uses_rt_r    <= uses_rt_d;
                ex_dst_r        <= write_reg_d;
                ex_reg_write_r  <= reg_write_d;
                ex_mem_to_reg_r <= mem_to_reg_d;
            end
            mem_dst_r        <= ex_dst_r;
            mem_reg_write_r  <= ex_reg_write_r;
            mem_mem_to_reg_r <= ex_mem_to_reg_r;
            wb_dst_r         <= mem_dst_r;
            wb_reg_write_r   <= mem_reg_write_r;
        end
    end

    // Watchdog: saturating stall-run counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run_r <= 3'd0;
            err_r       <= 1'b0;
        end else begin
            if (stall_s) begin
                if (stall_run_r != RUN_MAX) begin
                    stall_run_r <= stall_run_r + 3'd1;
                end else begin
                    stall_run_r <= stall_run_r;
                end
                if (stall_run_r == STALL_LIMIT) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end else begin
                stall_run_r <= 3'd0;
                err_r       <= err_r;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_cycles <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (flush_s) begin
                flush_cycles <= flush_cycles + 32'd1;
            end else begin
                flush_cycles <= flush_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Self-checking bench for hazard_unit. A behavioural model keeps the last three
// issued instructions as records (EX, MEM, WB). Expected outputs are derived
// from the hazard rules over those records. Directed scenarios cover:
//   - load-use stall,
//   - ALU-to-ALU forwarding, including $0 as destination,
//   - branch on a load result,
//   - branch on an ALU result,
//   - jr on an ALU result,
//   - reset asserted mid-stream,
//   - the watchdog, driven with a forced EX shadow.
// A randomized run follows the directed scenarios.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int MAX_STALL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, write_reg_d;
    logic       uses_rs_d, uses_rt_d, reg_write_d, mem_to_reg_d;
    logic       branch_d, jump_d, jump_reg_d, branch_taken_d;
    logic       stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic       hazard_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    hazard_unit #(.REG_ADDR_W(5), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
        .write_reg_d(write_reg_d), .reg_write_d(reg_write_d),
        .mem_to_reg_d(mem_to_reg_d), .branch_d(branch_d), .jump_d(jump_d),
        .jump_reg_d(jump_reg_d), .branch_taken_d(branch_taken_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
        .hazard_err(hazard_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // One issued instruction as seen by the hazard rules.
    typedef struct packed {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dst;
        logic       rw, m2r;
    } rec_t;

    rec_t        pipe [3];     // 0 = EX, 1 = MEM, 2 = WB
    logic        forcing;
    logic        e_stall, e_flush, e_fad, e_fbd, e_err;
    logic [1:0]  e_fae, e_fbe;
    int          run_len;
    logic [31:0] e_sc, e_fc;
    logic        obs_stall, obs_flush, obs_fad, obs_fbd, obs_err;
    logic [1:0]  obs_fae, obs_fbe;
    logic [31:0] obs_sc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hits(input rec_t s, input logic [4:0] r);
        return s.rw && (s.dst == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic u);
        if (!u) return 2'd0;
        if (hits(pipe[1], r)) return 2'd2;
        if (hits(pipe[2], r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        run_len = 0;
        e_err   = 1'b0;
        e_sc    = 32'd0;
        e_fc    = 32'd0;
    endtask

    task automatic predict();
        logic lw, br;
        lw = pipe[0].m2r && ((uses_rs_d && hits(pipe[0], rs_d)) ||
                             (uses_rt_d && hits(pipe[0], rt_d)));
        br = 1'b0;
        if (branch_d || jump_reg_d)
            br = br || hits(pipe[0], rs_d) || (pipe[1].m2r && hits(pipe[1], rs_d));
        if (branch_d)
            br = br || hits(pipe[0], rt_d) || (pipe[1].m2r && hits(pipe[1], rt_d));
        e_stall = lw || br;
        e_flush = (jump_d || branch_taken_d) && !e_stall;
        e_fad   = hits(pipe[1], rs_d) && !pipe[1].m2r;
        e_fbd   = hits(pipe[1], rt_d) && !pipe[1].m2r;
        e_fae   = fwd_sel(pipe[0].rs, pipe[0].urs);
        e_fbe   = fwd_sel(pipe[0].rt, pipe[0].urt);
    endtask

    task automatic check_all();
        predict();
        check("stall_f", stall_f, e_stall);
        check("stall_d", stall_d, e_stall);
        check("flush_e", flush_e, e_stall);
        check("flush_d", flush_d, e_flush);
        check("forward_a_d", forward_a_d, e_fad);
        check("forward_b_d", forward_b_d, e_fbd);
        check("forward_a_e", forward_a_e, e_fae);
        check("forward_b_e", forward_b_e, e_fbe);
        check("hazard_err", hazard_err, e_err);
`ifdef HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, e_sc);
        check("flush_cycles", flush_cycles, e_fc);
        obs_sc = stall_cycles;
`else
        obs_sc = e_sc;
`endif
        obs_stall = stall_d;  obs_flush = flush_d;
        obs_fad = forward_a_d; obs_fbd = forward_b_d;
        obs_fae = forward_a_e; obs_fbe = forward_b_e;
        obs_err = hazard_err;
    endtask

    // Model clock edge: watchdog, counters, then the pipeline shift.
    task automatic advance();
        rec_t d;
        if (e_stall) begin
            if (run_len == MAX_STALL) e_err = 1'b1;
            if (run_len < 7) run_len++;
            e_sc++;
        end else begin
            run_len = 0;
        end
        if (e_flush) e_fc++;
        d = '{rs: rs_d, rt: rt_d, urs: uses_rs_d, urt: uses_rt_d,
              dst: write_reg_d, rw: reg_write_d, m2r: mem_to_reg_d};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e_stall ? rec_t'(0) : d;
        if (forcing) begin
            pipe[0].dst = 5'd8; pipe[0].rw = 1'b1; pipe[0].m2r = 1'b1;
        end
    endtask

    task automatic drive_idle();
        rs_d = 5'd0; rt_d = 5'd0; uses_rs_d = 1'b0; uses_rt_d = 1'b0;
        write_reg_d = 5'd0; reg_write_d = 1'b0; mem_to_reg_d = 1'b0;
        branch_d = 1'b0; jump_d = 1'b0; jump_reg_d = 1'b0; branch_taken_d = 1'b0;
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] wd, input logic rw, input logic m2r,
                        input logic br, input logic j, input logic jr, input logic bt);
        @(negedge clk);
        rs_d = rs; rt_d = rt; uses_rs_d = urs; uses_rt_d = urt;
        write_reg_d = wd; reg_write_d = rw; mem_to_reg_d = m2r;
        branch_d = br; jump_d = j; jump_reg_d = jr; branch_taken_d = bt;
        #1;
        check_all();
        @(posedge clk);
        advance();
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic apply_reset();
        #1;
        drive_idle();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_stall", obs_stall, 1'b0);
        check("rst_err", obs_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forcing = 1'b0;
        drive_idle();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load-use: lw $8,0($29) ; add $9,$8,$10
        step(29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
        step(8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        check("lu_stall", obs_stall, 1'b1);
        step(8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        check("lu_release", obs_stall, 1'b0);
        nop(1);
        check("lu_fwd_wb", obs_fae, 2'd1);
        nop(3);

        // Back-to-back ALU: add $8,$1,$2 ; sub $11,$8,$8
        step(1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        step(8, 8, 1, 1, 11, 1, 0, 0, 0, 0, 0);
        check("alu_nostall", obs_stall, 1'b0);
        nop(1);
        check("alu_fwd_a", obs_fae, 2'd2);
        check("alu_fwd_b", obs_fbe, 2'd2);
        // Same with $0 as destination: no forwarding.
        step(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 0);
        check("r0_nostall", obs_stall, 1'b0);
        nop(1);
        check("r0_fwd_a", obs_fae, 2'd0);
        nop(3);

        // Branch on load: lw $8 ; beq $8,$9 (taken)
        step(29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
        step(8, 9, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        check("bl_stall1", obs_stall, 1'b1);
        check("bl_noflush1", obs_flush, 1'b0);
        step(8, 9, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        check("bl_stall2", obs_stall, 1'b1);
        check("bl_noflush2", obs_flush, 1'b0);
        step(8, 9, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        check("bl_release", obs_stall, 1'b0);
        check("bl_flush", obs_flush, 1'b1);
        check("bl_err", obs_err, 1'b0);
        nop(3);

        // Branch on ALU result: add $8 ; beq $8,$9 (taken)
        step(1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0);
        step(8, 9, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        check("ba_stall", obs_stall, 1'b1);
        step(8, 9, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        check("ba_release", obs_stall, 1'b0);
        check("ba_fwd_a_d", obs_fad, 1'b1);
        nop(3);

        // jr $8 after ori $8,$1,imm: rs only.
        step(1, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0);
        step(8, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        check("jr_stall", obs_stall, 1'b1);
        step(8, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        check("jr_release", obs_stall, 1'b0);
        check("jr_fwd_a_d", obs_fad, 1'b1);
        nop(3);

        // Reset mid-stream with lw $8 in EX, then add using $8: no stall.
        step(29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0);
        apply_reset();
        step(8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 0);
        check("post_rst_nostall", obs_stall, 1'b0);

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic br, jr;
            br = ($urandom_range(0, 3) == 0);
            jr = !br && ($urandom_range(0, 5) == 0);
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), br, ($urandom_range(0, 7) == 0),
                 jr, br && 1'($urandom));
        end
        nop(3);

        // Watchdog: hold a D dependency on a forced load in EX.
        apply_reset();
        @(negedge clk);
        force dut.ex_dst_r        = 5'd8;
        force dut.ex_reg_write_r  = 1'b1;
        force dut.ex_mem_to_reg_r = 1'b1;
        forcing = 1'b1;
        pipe[0].dst = 5'd8; pipe[0].rw = 1'b1; pipe[0].m2r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(8, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0);
            check("wd_stall", obs_stall, 1'b1);
            check("wd_err_pre", obs_err, 1'b0);
        end
        nop(1);
        check("wd_err_set", obs_err, 1'b1);
`ifdef HAZARD_PERF_EN
        check("wd_stall_cycles", obs_sc, 32'd3);
`endif
        nop(2);
        check("wd_err_sticky", obs_err, 1'b1);
        @(negedge clk);
        release dut.ex_dst_r;
        release dut.ex_reg_write_r;
        release dut.ex_mem_to_reg_r;
        forcing = 1'b0;
        apply_reset();
        nop(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
